// File: rtl/wb_bridge_pkg.sv
// wb_bridge_nway shared types: FSM encoding, error data, counter width.
// Imported by the bridge, its decoder and the bus interface.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int          CNT_W        = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_bridge_nway_if.sv
// Upstream slave port plus NUM_PORTS packed downstream master ports.
// slave = bridge side, master = surrounding system (upstream + targets).
interface wb_bridge_nway_if
  import wb_bridge_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                            wbs_stb_i;
  logic                            wbs_cyc_i;
  logic                            wbs_we_i;
  logic [3:0]                      wbs_sel_i;
  logic [31:0]                     wbs_dat_i;
  logic [31:0]                     wbs_adr_i;
  logic                            wbs_ack_o;
  logic                            wbs_err_o;
  logic [31:0]                     wbs_dat_o;

  logic [NUM_PORTS-1:0]            wbm_stb_o;
  logic [NUM_PORTS-1:0]            wbm_cyc_o;
  logic [NUM_PORTS-1:0]            wbm_we_o;
  logic [4*NUM_PORTS-1:0]          wbm_sel_o;
  logic [ADDR_WIDTH*NUM_PORTS-1:0] wbm_adr_o;
  logic [32*NUM_PORTS-1:0]         wbm_dat_o;
  logic [32*NUM_PORTS-1:0]         wbm_dat_i;
  logic [NUM_PORTS-1:0]            wbm_ack_i;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o,
    output wbm_stb_o, wbm_cyc_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o,
    input  wbm_stb_o, wbm_cyc_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_bridge_decoder.sv
// Priority base/mask window decoder; lowest matching index wins.
// Purely combinational so crossbars can reuse it per initiator.
module wb_bridge_decoder
  import wb_bridge_pkg::*;
#(
  parameter int                    NUM_PORTS = 4,
  parameter logic [NUM_PORTS*32-1:0] PORT_BASE = '0,
  parameter logic [NUM_PORTS*32-1:0] PORT_MASK = '0,
  parameter int                    IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [31:0]      adr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan downward so the lowest hitting index is the last writer.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((adr_i & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_bridge_nway.sv
// Registered N-way Wishbone classic bridge, one downstream port at a time.
// Define WB_BRIDGE_TIMEOUT_EN to enable the downstream timeout counter.
module wb_bridge_nway
  import wb_bridge_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter logic [NUM_PORTS*32-1:0] PORT_BASE = {
    32'h3003_0000, 32'h3002_0000,
    32'h3001_0000, 32'h3000_0000
  },
  parameter logic [NUM_PORTS*32-1:0] PORT_MASK = {
    4{32'hffff_0000}
  },
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input logic             wb_clk_i,
  input logic             wb_rst_n_i,
  wb_bridge_nway_if.slave bus
);

  localparam int IW = idx_w(NUM_PORTS);

  if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_np_chk
    $error("NUM_PORTS out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_to_chk
    $error("TIMEOUT_CYCLES out of range");
  end

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdat_q, wdat_d;
  logic [31:0]           rdat_q, rdat_d;
  logic                  rerr_q, rerr_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  dec_hit;
  logic [IW-1:0]         dec_idx;
  logic [31:0]           mask_sel;
  logic [31:0]           off_full;
  logic                  ack_sel;
  logic [31:0]           rdat_sel;
  logic                  req_new;

`ifdef WB_BRIDGE_TIMEOUT_EN
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
`endif

  wb_bridge_decoder #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BASE (PORT_BASE),
    .PORT_MASK (PORT_MASK),
    .IDX_W     (IW)
  ) u_dec (
    .adr_i (bus.wbs_adr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  always_comb begin
    mask_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dec_idx == IW'(i)) begin
        mask_sel = PORT_MASK[32*i +: 32];
      end
    end
    off_full = bus.wbs_adr_i & ~mask_sel;
  end

  // Only the latched port sees any activity; all other fields stay 0.
  always_comb begin
    bus.wbm_stb_o = '0;
    bus.wbm_cyc_o = '0;
    bus.wbm_we_o  = '0;
    bus.wbm_sel_o = '0;
    bus.wbm_adr_o = '0;
    bus.wbm_dat_o = '0;
    ack_sel       = 1'b0;
    rdat_sel      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state_q == ST_REQ && idx_q == IW'(i)) begin
        bus.wbm_stb_o[i]          = 1'b1;
        bus.wbm_cyc_o[i]          = 1'b1;
        bus.wbm_we_o[i]           = we_q;
        bus.wbm_sel_o[4*i +: 4]   = sel_q;
        bus.wbm_adr_o[ADDR_WIDTH*i +: ADDR_WIDTH] = adr_q;
        bus.wbm_dat_o[32*i +: 32] = wdat_q;
        ack_sel                   = bus.wbm_ack_i[i];
        rdat_sel                  = bus.wbm_dat_i[32*i +: 32];
      end
    end
  end

  // While the response pulse is out the upstream still holds the
  // finished request, so it must not be accepted a second time.
  assign req_new = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q & ~err_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
  assign cnt_inc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_new) begin
          idx_d  = dec_idx;
          adr_d  = off_full[ADDR_WIDTH-1:0];
          we_d   = bus.wbs_we_i;
          sel_d  = bus.wbs_sel_i;
          wdat_d = bus.wbs_dat_i;
          if (dec_hit) begin
            state_d = ST_REQ;
`ifdef WB_BRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = ST_RESP;
            rerr_d  = 1'b1;
            rdat_d  = ERR_DATA;
          end
        end
      end
      ST_REQ: begin
        if (!bus.wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_sel) begin
          state_d = ST_RESP;
          rerr_d  = 1'b0;
          rdat_d  = rdat_sel;
        end
`ifdef WB_BRIDGE_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_RESP;
          rerr_d  = 1'b1;
          rdat_d  = ERR_DATA;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ack_d   = ~rerr_q;
        err_d   = rerr_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef WB_BRIDGE_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = err_q;
  assign bus.wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Directed bench for wb_bridge_nway with a small wait-state slave model.
// Honors WB_BRIDGE_TIMEOUT_EN (TIMEOUT_CYCLES=8 when defined).
module tb_wb_bridge_nway;
  import wb_bridge_pkg::*;

  localparam int NP = 4;
`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_bridge_nway_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32)) bus ();

  wb_bridge_nway #(
    .NUM_PORTS      (NP),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  logic [NP-1:0] ack_en;
  logic [NP-1:0] spur;
  int unsigned   wait_cfg [NP];
  logic [31:0]   rd_cfg   [NP];
  int unsigned   wcnt     [NP];

  always_comb begin
    bus.wbm_ack_i = '0;
    bus.wbm_dat_i = '0;
    for (int i = 0; i < NP; i++) begin
      bus.wbm_ack_i[i] = spur[i] | (ack_en[i] & bus.wbm_stb_o[i]
                         & (wcnt[i] == wait_cfg[i]));
      bus.wbm_dat_i[32*i +: 32] = rd_cfg[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      wcnt[i] <= (bus.wbm_stb_o[i] && !bus.wbm_ack_i[i]) ? wcnt[i] + 1 : 0;
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
    bus.wbs_adr_i = a;
    bus.wbs_we_i  = w;
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = s;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
  endtask

  task automatic drop_req();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic w,
                         input logic [31:0] d,
                         output logic ak, output logic er,
                         output logic [31:0] rd, output int e);
    drive_req(a, w, d, 4'hF);
    ak = 1'b0;
    er = 1'b0;
    rd = '0;
    e  = -1;
    while (e < 40 && !ak && !er) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      ak = bus.wbs_ack_o;
      er = bus.wbs_err_o;
      rd = bus.wbs_dat_o;
    end
    drop_req();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drop_req();
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    ack_en = '0;
    spur   = '0;
    for (int i = 0; i < NP; i++) begin
      wait_cfg[i] = 0;
      rd_cfg[i]   = '0;
    end
    #12;
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbm_cyc_o !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_wbm: stb=%b cyc=%b want 0",
               bus.wbm_stb_o, bus.wbm_cyc_o);
    end
    n_cmp++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_wbs: ack=%b err=%b dat=%h want 0",
               bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    ack_en[1] = 1'b1;
    wait_cfg[1] = 0;
    drive_req(32'h3001_0010, 1'b1, 32'h1234_5678, 4'hF);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0010 || bus.wbm_cyc_o !== 4'b0010
        || bus.wbm_we_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL wr_ctl: stb=%b cyc=%b we=%b want 0010",
               bus.wbm_stb_o, bus.wbm_cyc_o, bus.wbm_we_o);
    end
    n_cmp++;
    if (bus.wbm_adr_o[63:32] !== 32'h0000_0010) begin
      n_bad++;
      $display("FAIL wr_adr: got %h want 00000010", bus.wbm_adr_o[63:32]);
    end
    n_cmp++;
    if (bus.wbm_dat_o[63:32] !== 32'h1234_5678 || bus.wbm_sel_o[7:4] !== 4'hF
        || bus.wbm_dat_o[31:0] !== 32'h0) begin
      n_bad++;
      $display("FAIL wr_dat: dat=%h sel=%h want 12345678 f",
               bus.wbm_dat_o[63:32], bus.wbm_sel_o[7:4]);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbs_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_e1: stb=%b ack=%b want 0 0",
               bus.wbm_stb_o, bus.wbs_ack_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_e2: ack=%b err=%b want 1 0",
               bus.wbs_ack_o, bus.wbs_err_o);
    end
    drop_req();
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_pulse: ack=%b want 0", bus.wbs_ack_o);
    end
  endtask

  task automatic test_read_wait();
    ack_en[3]   = 1'b1;
    wait_cfg[3] = 3;
    rd_cfg[3]   = 32'hCAFE_F00D;
    drive_req(32'h3003_0004, 1'b0, 32'h0, 4'hF);
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.wbs_ack_o !== (e == 5)) begin
        n_bad++;
        $display("FAIL rd_ack_e%0d: got %b want %b",
                 e, bus.wbs_ack_o, (e == 5));
      end
      if (e == 0) begin
        n_cmp++;
        if (bus.wbm_adr_o[127:96] !== 32'h4 || bus.wbm_stb_o !== 4'b1000) begin
          n_bad++;
          $display("FAIL rd_adr: adr=%h stb=%b want 4 1000",
                   bus.wbm_adr_o[127:96], bus.wbm_stb_o);
        end
      end
      if (e == 5) begin
        n_cmp++;
        if (bus.wbs_dat_o !== 32'hCAFE_F00D) begin
          n_bad++;
          $display("FAIL rd_dat: got %h want cafef00d", bus.wbs_dat_o);
        end
        drop_req();
      end
    end
  endtask

  task automatic test_unmapped();
    drive_req(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL um_e0: stb=%b err=%b want 0 0",
               bus.wbm_stb_o, bus.wbs_err_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_err_o !== 1'b1 || bus.wbs_ack_o !== 1'b0
        || bus.wbs_dat_o !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL um_e1: err=%b ack=%b dat=%h want 1 0 deadbeef",
               bus.wbs_err_o, bus.wbs_ack_o, bus.wbs_dat_o);
    end
    drop_req();
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL um_pulse: err=%b want 0", bus.wbs_err_o);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    ack_en[0] = 1'b0;
    drive_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    ok = 1'b1;
`ifdef WB_BRIDGE_TIMEOUT_EN
    for (int e = 0; e < TO; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wbm_stb_o !== 4'b0001 || bus.wbs_err_o !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL to_hold: got %b want 1", ok);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL to_drop: stb=%b err=%b want 0 0",
               bus.wbm_stb_o, bus.wbs_err_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_err_o !== 1'b1 || bus.wbs_ack_o !== 1'b0
        || bus.wbs_dat_o !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL to_err: err=%b ack=%b dat=%h want 1 0 deadbeef",
               bus.wbs_err_o, bus.wbs_ack_o, bus.wbs_dat_o);
    end
    drop_req();
    @(posedge clk);
    @(negedge clk);
`else
    for (int e = 0; e < 1000; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wbm_stb_o !== 4'b0001 || bus.wbs_err_o !== 1'b0
          || bus.wbs_ack_o !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL noto_hold: got %b want 1", ok);
    end
    drop_req();
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL noto_drop: stb=%b err=%b want 0 0",
               bus.wbm_stb_o, bus.wbs_err_o);
    end
`endif
  endtask

  task automatic test_abort();
    logic        ak, er;
    logic [31:0] rd;
    int          e;
    ack_en[2] = 1'b0;
    drive_req(32'h3002_0008, 1'b0, 32'h0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    spur[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0100 || bus.wbs_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_spur: stb=%b ack=%b want 0100 0",
               bus.wbm_stb_o, bus.wbs_ack_o);
    end
    @(posedge clk);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0;
    spur[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbm_cyc_o !== 4'b0
        || bus.wbs_ack_o !== 1'b0 || bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_drop: stb=%b cyc=%b ack=%b err=%b want 0",
               bus.wbm_stb_o, bus.wbm_cyc_o, bus.wbs_ack_o, bus.wbs_err_o);
    end
    spur = '0;
    drop_req();
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_noresp: ack=%b err=%b want 0 0",
               bus.wbs_ack_o, bus.wbs_err_o);
    end
    ack_en[2]   = 1'b1;
    wait_cfg[2] = 1;
    rd_cfg[2]   = 32'h2222_0002;
    run_txn(32'h3002_0000, 1'b0, 32'h0, ak, er, rd, e);
    n_cmp++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'h2222_0002 || e != 3) begin
      n_bad++;
      $display("FAIL ab_retry: ack=%b err=%b dat=%h edge=%0d want 1 0 22220002 3",
               ak, er, rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic        ak, er;
    logic [31:0] rd;
    int          e;
    ack_en[0]   = 1'b1;
    wait_cfg[0] = 0;
    rd_cfg[0]   = 32'h1111_0001;
    ack_en[3]   = 1'b1;
    wait_cfg[3] = 0;
    rd_cfg[3]   = 32'h3333_0003;
    run_txn(32'h3000_0100, 1'b1, 32'h5555_AAAA, ak, er, rd, e);
    n_cmp++;
    if (ak !== 1'b1 || er !== 1'b0 || e != 2) begin
      n_bad++;
      $display("FAIL b2b_first: ack=%b err=%b edge=%0d want 1 0 2", ak, er, e);
    end
    run_txn(32'h3003_0200, 1'b0, 32'h0, ak, er, rd, e);
    n_cmp++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'h3333_0003 || e != 2) begin
      n_bad++;
      $display("FAIL b2b_second: ack=%b err=%b dat=%h edge=%0d want 1 0 33330003 2",
               ak, er, rd, e);
    end
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h3333_0003) begin
      n_bad++;
      $display("FAIL b2b_hold: ack=%b dat=%h want 0 33330003",
               bus.wbs_ack_o, bus.wbs_dat_o);
    end
  endtask

  task automatic test_reset_mid();
    logic        ak, er;
    logic [31:0] rd;
    int          e;
    ack_en[1] = 1'b0;
    drive_req(32'h3001_0020, 1'b1, 32'hAAAA_5555, 4'h3);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL rm_pre: stb=%b want 0010", bus.wbm_stb_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.wbm_stb_o !== 4'b0 || bus.wbm_cyc_o !== 4'b0
        || bus.wbm_we_o !== 4'b0 || bus.wbm_sel_o !== 16'h0
        || bus.wbm_adr_o !== 128'h0 || bus.wbm_dat_o !== 128'h0) begin
      n_bad++;
      $display("FAIL rm_wbm: stb=%b cyc=%b we=%b sel=%h want all 0",
               bus.wbm_stb_o, bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_sel_o);
    end
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_err_o !== 1'b0
        || bus.wbs_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL rm_wbs: ack=%b err=%b dat=%h want 0",
               bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o);
    end
    drop_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_en[0]   = 1'b1;
    wait_cfg[0] = 2;
    rd_cfg[0]   = 32'h0BAD_F00D;
    run_txn(32'h3000_0000, 1'b0, 32'h0, ak, er, rd, e);
    n_cmp++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'h0BAD_F00D || e != 4) begin
      n_bad++;
      $display("FAIL rm_after: ack=%b err=%b dat=%h edge=%0d want 1 0 0badf00d 4",
               ak, er, rd, e);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
